// File: rtl/rowptr_nnz_gen.sv
// Turns a CSR row-pointer stream into per-row non-zero counts for the row kernel's TIMES port.
// Optional feature: define ROWPTR_MONO_CHECK_EN to flag non-monotonic row pointers via sticky err.
module rowptr_nnz_gen #(
  parameter int PTR_W  = 32,
  parameter int ROWS_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROWS_W-1:0] num_rows,
  input  logic [PTR_W-1:0]  s_axis_rowptr_tdata,
  input  logic              s_axis_rowptr_tvalid,
  output logic              s_axis_rowptr_tready,
  output logic [PTR_W-1:0]  m_axis_times_tdata,
  output logic              m_axis_times_tvalid,
  input  logic              m_axis_times_tready,
  output logic              busy,
  output logic              done,
  output logic [ROWS_W-1:0] rows_sent,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, FIRST, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  prev_q, prev_d;
  logic [PTR_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [ROWS_W-1:0] remaining_q, remaining_d;
  logic [ROWS_W-1:0] rows_sent_q, rows_sent_d;
  logic              err_q, err_d;
  logic              in_hs, out_hs, mono_bad;
  logic [PTR_W-1:0]  diff;

  // Ready only looks at registered state and the sink's ready, never at tvalid.
  always_comb begin
    s_axis_rowptr_tready = 1'b0;
    case (state_q)
      FIRST:   s_axis_rowptr_tready = 1'b1;
      RUN:     s_axis_rowptr_tready = (~out_valid_q | m_axis_times_tready) &&
                                      (remaining_q != '0);
      default: s_axis_rowptr_tready = 1'b0;
    endcase
  end

  assign in_hs  = s_axis_rowptr_tvalid & s_axis_rowptr_tready;
  assign out_hs = out_valid_q & m_axis_times_tready;
  assign diff   = s_axis_rowptr_tdata - prev_q;

`ifdef ROWPTR_MONO_CHECK_EN
  assign mono_bad = s_axis_rowptr_tdata < prev_q;
`else
  assign mono_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~out_hs;
    remaining_d = remaining_q;
    rows_sent_d = rows_sent_q + ROWS_W'(out_hs);
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = num_rows;
          rows_sent_d = '0;
          err_d       = 1'b0;
          state_d     = (num_rows != '0) ? FIRST : DONE;
        end
      end
      FIRST: begin
        if (in_hs) begin
          prev_d  = s_axis_rowptr_tdata;
          state_d = RUN;
        end
      end
      RUN: begin
        // The output register refills in the same cycle it drains.
        if (in_hs) begin
          out_valid_d = 1'b1;
          prev_d      = s_axis_rowptr_tdata;
          remaining_d = remaining_q - ROWS_W'(1);
          if (mono_bad) begin
            out_data_d = '0;
            err_d      = 1'b1;
          end else begin
            out_data_d = diff;
          end
          if (remaining_q == ROWS_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      remaining_q <= '0;
      rows_sent_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      remaining_q <= remaining_d;
      rows_sent_q <= rows_sent_d;
      err_q       <= err_d;
    end
  end

  assign m_axis_times_tdata  = out_data_q;
  assign m_axis_times_tvalid = out_valid_q;
  assign rows_sent           = rows_sent_q;
  assign err                 = err_q;
  assign busy                = (state_q == FIRST) || (state_q == RUN) || (state_q == DRAIN);
  assign done                = (state_q == DONE);

endmodule
